// File: rtl/board_io_ctrl.sv
// board_io_ctrl: switch synchroniser/debouncer with sticky change flags and IRQ,
// plus a two-stage registered LED driver with global PWM brightness.
module board_io_ctrl #(
  parameter int SW_WIDTH        = 8,
  parameter int LED_WIDTH       = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int PWM_BITS        = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SW_WIDTH-1:0]  i_sw,
  output logic [SW_WIDTH-1:0]  o_sw_db,
  output logic [SW_WIDTH-1:0]  o_sw_event,
  input  logic [SW_WIDTH-1:0]  i_event_clr,
  output logic                 o_irq,
  input  logic [LED_WIDTH-1:0] i_led,
  input  logic [PWM_BITS-1:0]  i_led_bright,
  output logic [LED_WIDTH-1:0] o_led
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_WIDTH-1:0]  sync1_q, sync2_q;
  logic [SW_WIDTH-1:0]  db_q, db_d, db_dly_q;
  logic [SW_WIDTH-1:0]  event_q, event_d;
  logic [CNT_W-1:0]     cnt_q [SW_WIDTH];
  logic [CNT_W-1:0]     cnt_d [SW_WIDTH];

  logic [LED_WIDTH-1:0] led_s1_q, led_q, led_d;
  logic [PWM_BITS-1:0]  bright_s1_q;
  logic [PWM_BITS-1:0]  pwm_q;
  logic                 led_on;

  // Debounce: count consecutive mismatch cycles, accept on the last one.
  // The counter clears on accept, so it never exceeds DEBOUNCE_CYCLES-1.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < SW_WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    // A fresh change wins over a coincident clear.
    event_d = (event_q & ~i_event_clr) | (db_q ^ db_dly_q);
  end

  // Switch path registers: synchroniser, debounce state, change flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      event_q  <= '0;
      for (int i = 0; i < SW_WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= i_sw;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      event_q  <= event_d;
      for (int i = 0; i < SW_WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // LED gating: all-ones brightness bypasses the compare to reach 100% duty.
  always_comb begin
    led_on = (pwm_q < bright_s1_q) || (&bright_s1_q);
    led_d  = led_on ? led_s1_q : '0;
  end

  // LED pipeline and free-running PWM counter (never reset by brightness changes).
  always_ff @(posedge clk) begin
    if (rst) begin
      led_s1_q    <= '0;
      bright_s1_q <= '0;
      pwm_q       <= '0;
      led_q       <= '0;
    end else begin
      led_s1_q    <= i_led;
      bright_s1_q <= i_led_bright;
      pwm_q       <= pwm_q + PWM_BITS'(1);
      led_q       <= led_d;
    end
  end

  assign o_sw_db    = db_q;
  assign o_sw_event = event_q;
  assign o_irq      = |event_q;
  assign o_led      = led_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Bench for board_io_ctrl: directed scenarios plus randomized traffic, all
// checked every cycle against a history-window reference model.
module tb_board_io_ctrl;

  localparam int SW  = 8;
  localparam int LW  = 8;
  localparam int DEB = 4;
  localparam int PB  = 2;
  localparam int M   = 1 << PB;

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] i_sw, i_event_clr, o_sw_db, o_sw_event;
  logic          o_irq;
  logic [LW-1:0] i_led, o_led;
  logic [PB-1:0] i_led_bright;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [SW-1:0] hist [0:DEB+1];   // hist[0] = raw input sampled at newest edge
  logic [SW-1:0] db_m, db_prev_m, ev_m;
  logic [LW-1:0] led_m, led_prev;
  int            b_prev, nedge;

  board_io_ctrl #(
    .SW_WIDTH(SW), .LED_WIDTH(LW), .DEBOUNCE_CYCLES(DEB), .PWM_BITS(PB)
  ) dut (
    .clk(clk), .rst(rst), .i_sw(i_sw), .o_sw_db(o_sw_db),
    .o_sw_event(o_sw_event), .i_event_clr(i_event_clr), .o_irq(o_irq),
    .i_led(i_led), .i_led_bright(i_led_bright), .o_led(o_led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Accept a switch value once the synchronised input has disagreed with the
  // accepted value for DEB consecutive cycles; synchronised value lags raw by 2.
  task automatic model_edge();
    logic [SW-1:0] new_db, chg;
    logic          mism;
    int            phase;
    if (rst) begin
      for (int k = 0; k <= DEB + 1; k++) hist[k] = '0;
      db_m = '0; db_prev_m = '0; ev_m = '0;
      led_m = '0; led_prev = '0; b_prev = 0; nedge = 0;
    end else begin
      for (int k = DEB + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = i_sw;
      new_db = db_m;
      for (int ch = 0; ch < SW; ch++) begin
        mism = 1'b1;
        for (int k = 2; k <= DEB + 1; k++)
          if (hist[k][ch] == db_m[ch]) mism = 1'b0;
        if (mism) new_db[ch] = ~db_m[ch];
      end
      chg       = db_m ^ db_prev_m;
      db_prev_m = db_m;
      db_m      = new_db;
      ev_m      = (ev_m & ~i_event_clr) | chg;
      phase     = nedge % M;
      led_m     = ((phase < b_prev) || (b_prev == M - 1)) ? led_prev : '0;
      led_prev  = i_led;
      b_prev    = int'(i_led_bright);
      nedge++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("sw_db",    32'(o_sw_db),    32'(db_m));
    chk("sw_event", 32'(o_sw_event), 32'(ev_m));
    chk("irq",      32'(o_irq),      32'(|ev_m));
    chk("led",      32'(o_led),      32'(led_m));
  endtask

  initial begin
    int n, on_cnt;
    logic [SW-1:0] r;
    rst = 1'b1; i_sw = '0; i_event_clr = '0; i_led = '0; i_led_bright = '0;
    for (int k = 0; k <= DEB + 1; k++) hist[k] = '0;
    repeat (3) tick();
    chk("reset_all_zero", 32'({o_sw_db, o_sw_event, o_led, 7'd0, o_irq}), 32'd0);

    // clean step on channel 0: accepted at edge DEB+2, flagged one edge later
    rst = 1'b0; i_sw = 8'h01;
    repeat (5) tick();
    chk("step_db_edge5", 32'(o_sw_db[0]), 32'd0);
    tick();
    chk("step_db_edge6", 32'(o_sw_db[0]), 32'd1);
    chk("step_ev_edge6", 32'(o_sw_event[0]), 32'd0);
    tick();
    chk("step_ev_edge7", 32'(o_sw_event[0]), 32'd1);
    chk("step_irq_edge7", 32'(o_irq), 32'd1);

    // glitch on channel 3 shorter than the debounce window
    i_sw = 8'h09;
    repeat (3) tick();
    i_sw = 8'h01;
    repeat (10) tick();
    chk("glitch_db3", 32'(o_sw_db[3]), 32'd0);
    chk("glitch_ev3", 32'(o_sw_event[3]), 32'd0);

    // clear strobe, then clear coincident with a new change
    i_event_clr = 8'h01;
    tick();
    i_event_clr = '0;
    chk("clr_ev0", 32'(o_sw_event[0]), 32'd0);
    chk("clr_irq", 32'(o_irq), 32'd0);
    i_sw = 8'h00;
    n = 0;
    while (o_sw_db[0] !== 1'b0 && n < 20) begin tick(); n++; end
    chk("fall_accept_bound", 32'(o_sw_db[0]), 32'd0);
    i_event_clr = 8'h01;
    tick();
    i_event_clr = '0;
    chk("clr_vs_set_ev0", 32'(o_sw_event[0]), 32'd1);
    i_event_clr = 8'h01;
    tick();
    i_event_clr = '0;

    // PWM duty for each brightness with all LEDs requested
    i_led = 8'hFF;
    for (int b = 0; b < M; b++) begin
      i_led_bright = PB'(b);
      repeat (2) tick();
      on_cnt = 0;
      repeat (2 * M) begin
        tick();
        if (o_led === 8'hFF) on_cnt++;
        else chk("pwm_off_value", 32'(o_led), 32'd0);
      end
      chk($sformatf("pwm_duty_b%0d", b), 32'(on_cnt), 32'((b == M - 1) ? 2 * M : 2 * b));
    end

    // two-cycle LED latency at full brightness
    i_led = 8'h00;
    repeat (3) tick();
    i_led = 8'hA5;
    tick();
    chk("led_lat_1", 32'(o_led), 32'h00);
    tick();
    chk("led_lat_2", 32'(o_led), 32'hA5);

    // reset mid-debounce discards the partial count
    i_sw = 8'h20;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("midrst_zero", 32'({o_sw_db, o_sw_event, o_led, 7'd0, o_irq}), 32'd0);
    rst = 1'b0;
    n = 0;
    while (o_sw_db[5] !== 1'b1 && n < 20) begin tick(); n++; end
    chk("midrst_accept_edges", 32'(n), 32'(DEB + 2));
    tick();
    chk("midrst_event5", 32'(o_sw_event[5]), 32'd1);

    // randomized traffic
    for (int t = 0; t < 600; t++) begin
      r = '0;
      for (int ch = 0; ch < SW; ch++) r[ch] = ($urandom_range(0, 7) == 0);
      i_sw         = i_sw ^ r;
      i_event_clr  = 8'($urandom) & 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 9) == 0) i_led = 8'($urandom);
      if ($urandom_range(0, 15) == 0) i_led_bright = PB'($urandom);
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
